// File: rtl/fp_pkg.sv
// Shared fixed-point definitions for the FC datapath: Q-format defaults, divider FSM states, range limits.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package fp_pkg;

    // Q4.11 by default: 16-bit two's complement word with 11 fraction bits.
    localparam int FP_SIZE      = 16;
    localparam int FP_PRECISION = 11;

    // Divider FSM states. These are plain constants rather than an enum so that
    // legacy code can compare them directly.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    // Bit patterns of the largest and smallest representable Q values for a
    // SIZE-bit word. Only the low SIZE bits are meaningful. fx_min also serves
    // as the unsigned magnitude 2^(SIZE-1) of the most negative value.
    function automatic logic [63:0] fx_max(input int size);
        return (64'd1 << (size - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] fx_min(input int size);
        return 64'd1 << (size - 1);
    endfunction

endpackage

// File: rtl/fp_saturate.sv
// Applies a sign to an unsigned magnitude and clamps the result to the signed SIZE-bit Q range.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   mag       unsigned magnitude, MAG_W bits (MAG_W must be wider than SIZE)
//   sign      1 = negate the magnitude
//   value     signed SIZE-bit result, saturated to [MIN, MAX]
//   overflow  1 when the magnitude did not fit and value was clamped
module fp_saturate
    import fp_pkg::*;
#(
    parameter int SIZE  = FP_SIZE,
    parameter int MAG_W = FP_SIZE + FP_PRECISION
) (
    input  logic [MAG_W-1:0] mag,
    input  logic             sign,
    output logic [SIZE-1:0]  value,
    output logic             overflow
);

    localparam logic [63:0]      MAX64  = fx_max(SIZE);
    localparam logic [63:0]      MIN64  = fx_min(SIZE);
    localparam logic [SIZE-1:0]  FX_MAX = MAX64[SIZE-1:0];
    localparam logic [SIZE-1:0]  FX_MIN = MIN64[SIZE-1:0];

    // Magnitude limits in the wide domain. The negative side reaches one step
    // further than the positive side (two's complement asymmetry).
    localparam logic [MAG_W-1:0] LIM_POS = {{(MAG_W-SIZE){1'b0}}, FX_MAX};
    localparam logic [MAG_W-1:0] LIM_NEG = {{(MAG_W-SIZE){1'b0}}, FX_MIN};

    always_comb begin
        value    = '0;
        overflow = 1'b0;
        if (!sign) begin
            if (mag > LIM_POS) begin
                value    = FX_MAX;
                overflow = 1'b1;
            end else begin
                value = mag[SIZE-1:0];
            end
        end else begin
            if (mag > LIM_NEG) begin
                value    = FX_MIN;
                overflow = 1'b1;
            end else begin
                // Negating a zero magnitude gives +0. A magnitude of exactly
                // 2^(SIZE-1) wraps onto MIN, which is the right answer.
                value = -mag[SIZE-1:0];
            end
        end
    end

endmodule

// File: rtl/fp_divider.sv
// Sequential signed Q-format divider: (dividend << PRECISION) / divisor, restoring, one quotient bit per cycle.
// Latency: SIZE+PRECISION+1 cycles from accept to done (28 for Q4.11); 1 cycle for a zero divisor.
// Backpressure: none; start is sampled only while idle and ignored while busy, results are not held for a consumer.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start                 request, accepted when the FSM is idle
//   dividend, divisor     signed Q operands, captured on accept
//   busy                  high from the accept edge until the result edge
//   done                  one-cycle pulse marking a new result
//   quotient              signed Q result, held until the next done
//   overflow, div_by_zero result flags, updated together with quotient
module fp_divider
    import fp_pkg::*;
#(
    parameter int SIZE      = FP_SIZE,
    parameter int PRECISION = FP_PRECISION
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] quotient,
    output logic            overflow,
    output logic            div_by_zero
);

    localparam int N  = SIZE + PRECISION;
    localparam int CW = $clog2(N);

    localparam logic [63:0]     MAX64  = fx_max(SIZE);
    localparam logic [63:0]     MIN64  = fx_min(SIZE);
    localparam logic [SIZE-1:0] FX_MAX = MAX64[SIZE-1:0];
    localparam logic [SIZE-1:0] FX_MIN = MIN64[SIZE-1:0];

    logic [1:0]      state;
    logic            sign_q;      // result sign
    logic            dvd_neg;     // dividend sign, picks the divide-by-zero rail
    logic            zero_q;      // divisor was zero
    logic [N-1:0]    num;         // numerator, shifted out MSB-first; quotient bits shift in at the LSB
    logic [SIZE:0]   rem;         // partial remainder
    logic [SIZE-1:0] dvs;         // |divisor|
    logic [CW-1:0]   cnt;

    // Magnitudes are taken in SIZE bits treated as unsigned, so -2^(SIZE-1)
    // maps to 2^(SIZE-1) without loss.
    logic [SIZE-1:0] dvd_abs;
    logic [SIZE-1:0] dvs_abs;
    assign dvd_abs = dividend[SIZE-1] ? -dividend : dividend;
    assign dvs_abs = divisor[SIZE-1]  ? -divisor  : divisor;

    // One restoring step. A set bit shifted out of the remainder top means the
    // shifted value already exceeds any divisor, so the subtraction succeeds;
    // the modulo-2^(SIZE+1) difference is then still the correct remainder.
    logic [SIZE:0] rem_sh;
    logic          ge;
    logic [SIZE:0] rem_nxt;
    assign rem_sh  = {rem[SIZE-1:0], num[N-1]};
    assign ge      = rem[SIZE] | (rem_sh >= {1'b0, dvs});
    assign rem_nxt = ge ? (rem_sh - {1'b0, dvs}) : rem_sh;

    logic [SIZE-1:0] sat_val;
    logic            sat_ovf;

    fp_saturate #(
        .SIZE  (SIZE),
        .MAG_W (N)
    ) u_sat (
        .mag      (num),
        .sign     (sign_q),
        .value    (sat_val),
        .overflow (sat_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sign_q      <= 1'b0;
            dvd_neg     <= 1'b0;
            zero_q      <= 1'b0;
            num         <= '0;
            rem         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sign_q  <= dividend[SIZE-1] ^ divisor[SIZE-1];
                        dvd_neg <= dividend[SIZE-1];
                        zero_q  <= (divisor == '0);
                        num     <= {dvd_abs, {PRECISION{1'b0}}};
                        rem     <= '0;
                        dvs     <= dvs_abs;
                        cnt     <= CW'(N - 1);
                        busy    <= 1'b1;
                        // A zero divisor skips the iterations entirely.
                        state   <= (divisor == '0) ? ST_FINISH : ST_CALC;
                    end
                end
                ST_CALC: begin
                    rem <= rem_nxt;
                    num <= {num[N-2:0], ge};
                    if (cnt == '0) begin
                        state <= ST_FINISH;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_FINISH: begin
                    if (zero_q) begin
                        quotient    <= dvd_neg ? FX_MIN : FX_MAX;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= sat_val;
                        overflow    <= sat_ovf;
                        div_by_zero <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// Testbench for fp_divider: directed Q4.11 vectors with literal expectations,
// plus a cycle-by-cycle comparison against an arithmetic reference model.
module tb_fp_divider;

    localparam int SIZE = 16;
    localparam int PREC = 11;
    localparam int N    = SIZE + PREC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, overflow, div_by_zero;
    logic [15:0] quotient;

    fp_divider #(.SIZE(SIZE), .PRECISION(PREC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact rational result, truncated toward zero by integer
    // division, then clamped to the signed 16-bit range.
    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic ov, output logic dz,
                         output int lat);
        longint na, nb, r;
        na = longint'($signed(a));
        nb = longint'($signed(b));
        if (nb == 0) begin
            dz  = 1'b1;
            ov  = 1'b0;
            q   = (na < 0) ? 16'h8000 : 16'h7FFF;
            lat = 1;
        end else begin
            dz  = 1'b0;
            r   = (na * (longint'(1) << PREC)) / nb;
            lat = N + 1;
            if (r > 32767) begin
                q = 16'h7FFF; ov = 1'b1;
            end else if (r < -32768) begin
                q = 16'h8000; ov = 1'b1;
            end else begin
                q = r[15:0]; ov = 1'b0;
            end
        end
    endtask

    typedef struct {
        int          done_cyc;
        logic [15:0] q;
        logic        ov;
        logic        dz;
    } exp_t;

    exp_t        pend[$];
    logic [15:0] held_q  = '0;
    logic        held_ov = 1'b0;
    logic        held_dz = 1'b0;

    // Model tracking and per-cycle compare. Accepts are predicted at rising
    // edges (idle means nothing outstanding); outputs are compared at falling edges.
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(posedge clk or negedge clk or negedge rst_n);
            if (!rst_n) begin
                pend.delete();
                held_q  = '0;
                held_ov = 1'b0;
                held_dz = 1'b0;
            end else if (clk) begin
                cyc++;
                if (start && pend.size() == 0) begin
                    model(dividend, divisor, e.q, e.ov, e.dz, lat);
                    e.done_cyc = cyc + lat;
                    pend.push_back(e);
                end
            end else begin
                if (pend.size() > 0 && pend[0].done_cyc == cyc) begin
                    chk("cmp_done", done, 1);
                    chk("cmp_busy_at_done", busy, 0);
                    chk("cmp_quotient", quotient, pend[0].q);
                    chk("cmp_overflow", overflow, pend[0].ov);
                    chk("cmp_div_by_zero", div_by_zero, pend[0].dz);
                    held_q  = pend[0].q;
                    held_ov = pend[0].ov;
                    held_dz = pend[0].dz;
                    void'(pend.pop_front());
                end else begin
                    chk("cmp_no_done", done, 0);
                    chk("cmp_busy", busy, pend.size() > 0);
                    chk("cmp_hold_quotient", quotient, held_q);
                    chk("cmp_hold_overflow", overflow, held_ov);
                    chk("cmp_hold_div_by_zero", div_by_zero, held_dz);
                end
            end
        end
    end

    // Waits for done, counting falling edges; 0 means it never came.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: no done within 100 cycles (t=%0t)", $time);
        end
    endtask

    task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic eov, input logic edz, input int elat);
        int lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_quotient"}, quotient, eq);
        chk({nm, "_overflow"}, overflow, eov);
        chk({nm, "_div_by_zero"}, div_by_zero, edz);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] mq;
        logic        mov, mdz;
        int          mlat;
        int          lat;
        int          tot;

        // Hand-computed values that pin the reference model.
        model(16'h1800, 16'h1000, mq, mov, mdz, mlat);
        chk("model_3_div_2", mq, 16'h0C00);
        chk("model_lat", mlat, 28);
        model(16'hF800, 16'h1800, mq, mov, mdz, mlat);
        chk("model_trunc_neg", mq, 16'hFD56);
        model(16'h8000, 16'hF800, mq, mov, mdz, mlat);
        chk("model_sat_pos", {mq, 7'b0, mov}, {16'h7FFF, 8'h01});
        model(16'hF800, 16'h0000, mq, mov, mdz, mlat);
        chk("model_dbz", {mq, 7'b0, mdz}, {16'h8000, 8'h01});

        // Reset state.
        #1 rst_n = 1'b0;
        #3;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_div_by_zero", div_by_zero, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Main function, truncation and range edges.
        run_op("div_3_2",       16'h1800, 16'h1000, 16'h0C00, 1'b0, 1'b0, 28);
        run_op("div_m1_4",      16'hF800, 16'h2000, 16'hFE00, 1'b0, 1'b0, 28);
        run_op("trunc_pos",     16'h0800, 16'h1800, 16'h02AA, 1'b0, 1'b0, 28);
        run_op("trunc_neg",     16'hF800, 16'h1800, 16'hFD56, 1'b0, 1'b0, 28);
        run_op("sat_8_q",       16'h4000, 16'h0200, 16'h7FFF, 1'b1, 1'b0, 28);
        run_op("min_exact",     16'h8000, 16'h0800, 16'h8000, 1'b0, 1'b0, 28);
        run_op("min_div_m1",    16'h8000, 16'hF800, 16'h7FFF, 1'b1, 1'b0, 28);
        run_op("zero_num_neg",  16'h0000, 16'hF800, 16'h0000, 1'b0, 1'b0, 28);
        run_op("dbz_pos",       16'h0800, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 1);
        run_op("dbz_neg",       16'hF800, 16'h0000, 16'h8000, 1'b0, 1'b1, 1);

        // start pulsed mid-CALC with different operands is ignored.
        @(negedge clk);
        dividend = 16'h1800; divisor = 16'h1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        dividend = 16'h4000; divisor = 16'h0200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        tot = (lat == 0) ? 0 : lat + 5;
        chk("ignore_start_latency", tot, 28);
        chk("ignore_start_quotient", quotient, 16'h0C00);
        chk("ignore_start_overflow", overflow, 0);

        // start held through done: next operation starts on the following edge.
        @(negedge clk);
        dividend = 16'hF800; divisor = 16'h2000; start = 1'b1;
        @(negedge clk);
        wait_done(lat);
        chk("b2b_first_latency", lat, 28);
        chk("b2b_first_quotient", quotient, 16'hFE00);
        dividend = 16'h1800; divisor = 16'h1000;
        @(negedge clk);
        chk("b2b_no_gap_busy", busy, 1);
        chk("b2b_no_gap_done", done, 0);
        start = 1'b0;
        wait_done(lat);
        chk("b2b_second_latency", lat, 28);
        chk("b2b_second_quotient", quotient, 16'h0C00);

        // Reset in the middle of an operation.
        @(negedge clk);
        dividend = 16'h1800; divisor = 16'h1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_overflow", overflow, 0);
        chk("abort_div_by_zero", div_by_zero, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        run_op("after_reset", 16'h1800, 16'h1000, 16'h0C00, 1'b0, 1'b0, 28);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
